// File: rtl/branch_sequencer_if.sv
// Decode / ALU / PC-update handshake bundle for the branch sequencer.
// The master modport is the sequencer's view; slave is the surrounding datapath.
interface branch_sequencer_if;
  logic       instr_valid;
  logic [5:0] opcode;
  logic       instr_ready;
  logic       alu_start;
  logic [2:0] alu_op;
  logic       alu_done;
  logic       alu_zero;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       flush;

  modport master (
    input  instr_valid, opcode, alu_done, alu_zero,
    output instr_ready, alu_start, alu_op, pc_write, pc_src, flush
  );

  modport slave (
    output instr_valid, opcode, alu_done, alu_zero,
    input  instr_ready, alu_start, alu_op, pc_write, pc_src, flush
  );
endinterface

// File: rtl/branch_sequencer.sv
// Multicycle BEQ/BNE sequencer: launches an ALU subtract, resolves taken from the
// zero flag, issues one PC-update pulse and keeps saturating branch statistics.
module branch_sequencer #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned ALU_TIMEOUT = 8,
  parameter int unsigned TMO_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  branch_sequencer_if.master bus,
  output logic               busy,
  output logic               tmo_err,
  output logic [CNT_W-1:0]   branch_count,
  output logic [CNT_W-1:0]   taken_count
);

  localparam logic [5:0] OpBeq  = 6'h04;
  localparam logic [5:0] OpBne  = 6'h05;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;

  typedef enum logic [1:0] {StIdle, StLaunch, StExec, StUpdate} state_t;

  state_t             state_q;
  logic               alu_start_q;
  logic [2:0]         alu_op_q;
  logic               pc_write_q;
  logic [1:0]         pc_src_q;
  logic               flush_q;
  logic               tmo_err_q;
  logic [CNT_W-1:0]   branch_count_q;
  logic [CNT_W-1:0]   taken_count_q;
  logic [TMO_W-1:0]   tmo_cnt_q;
  logic               is_branch_q;
  logic               is_bne_q;
  logic               taken_q;

  logic               is_br_op;
  logic               res_taken;
  logic [TMO_W-1:0]   tmo_nxt;

  assign is_br_op  = (bus.opcode == OpBeq) || (bus.opcode == OpBne);
  assign res_taken = is_bne_q ? ~bus.alu_zero : bus.alu_zero;
  assign tmo_nxt   = tmo_cnt_q + TMO_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      alu_start_q    <= 1'b0;
      alu_op_q       <= AluAdd;
      pc_write_q     <= 1'b0;
      pc_src_q       <= 2'b00;
      flush_q        <= 1'b0;
      tmo_err_q      <= 1'b0;
      branch_count_q <= '0;
      taken_count_q  <= '0;
      tmo_cnt_q      <= '0;
      is_branch_q    <= 1'b0;
      is_bne_q       <= 1'b0;
      taken_q        <= 1'b0;
    end else begin
      // Pulse outputs default low; the transition into a state raises them.
      alu_start_q <= 1'b0;
      pc_write_q  <= 1'b0;
      flush_q     <= 1'b0;
      pc_src_q    <= 2'b00;

      case (state_q)
        StIdle: begin
          if (bus.instr_valid) begin
            is_branch_q <= is_br_op;
            is_bne_q    <= (bus.opcode == OpBne);
            if (is_br_op) begin
              state_q     <= StLaunch;
              alu_start_q <= 1'b1;
              alu_op_q    <= AluSub;
            end else begin
              state_q    <= StUpdate;
              taken_q    <= 1'b0;
              pc_write_q <= 1'b1;
            end
          end
        end

        StLaunch: begin
          tmo_cnt_q <= '0;
          state_q   <= StExec;
        end

        StExec: begin
          // A result arriving on the timeout cycle wins over the timeout.
          if (bus.alu_done) begin
            taken_q    <= res_taken;
            pc_write_q <= 1'b1;
            pc_src_q   <= {1'b0, res_taken};
            flush_q    <= res_taken;
            alu_op_q   <= AluAdd;
            state_q    <= StUpdate;
          end else if (tmo_nxt == TMO_W'(ALU_TIMEOUT)) begin
            tmo_cnt_q  <= tmo_nxt;
            tmo_err_q  <= 1'b1;
            taken_q    <= 1'b0;
            pc_write_q <= 1'b1;
            alu_op_q   <= AluAdd;
            state_q    <= StUpdate;
          end else begin
            tmo_cnt_q <= tmo_nxt;
          end
        end

        StUpdate: begin
          if (is_branch_q) begin
            if (branch_count_q != '1) begin
              branch_count_q <= branch_count_q + CNT_W'(1);
            end
            if (taken_q && (taken_count_q != '1)) begin
              taken_count_q <= taken_count_q + CNT_W'(1);
            end
          end
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.instr_ready = (state_q == StIdle);
  assign bus.alu_start   = alu_start_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.pc_write    = pc_write_q;
  assign bus.pc_src      = pc_src_q;
  assign bus.flush       = flush_q;
  assign busy            = (state_q != StIdle);
  assign tmo_err         = tmo_err_q;
  assign branch_count    = branch_count_q;
  assign taken_count     = taken_count_q;

endmodule
